divider_issue_ctrl: RTL and testbench

Front-end and result collector for the pipelined restoring divider chain in the position-calculation path. Accepts divide requests over a valid/ready handshake, issues them one per cycle into the first divider stage, and tracks tag and exception flags in order. It captures the last stage's quotient and remainder into a small result FIFO. Backpressure is credit-based because the divider chain itself cannot stall.

---
 rtl/divider_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_divider_issue_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_issue_ctrl.sv
// Issue/collect controller for the non-stallable restoring divider chain; LAT+2 cycles accept to out_valid.
// Credit counter bounds in-flight plus buffered results to DEPTH so neither FIFO can overflow.
module divider_issue_ctrl #(
   parameter int N     = 16,
   parameter int M     = 8,
   parameter int LAT   = N - M + 1,
   parameter int TAGW  = 4,
   parameter int DEPTH = 4,
   localparam int Q    = N - M + 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_dividend,
   input  logic [M-1:0]    in_divisor,
   input  logic [TAGW-1:0] in_tag,
   output logic            div_en,
   output logic [N-1:0]    div_dividend,
   output logic [M-1:0]    div_divisor,
   input  logic            res_rdy,
   input  logic [Q-1:0]    res_quotient,
   input  logic [M-1:0]    res_remainder,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [Q-1:0]    out_quotient,
   output logic [M-1:0]    out_remainder,
   output logic [TAGW-1:0] out_tag,
   output logic            out_dz,
   output logic            out_ovf,
   output logic            err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [TAGW-1:0] tag;
      logic            dz;
      logic            ovf;
   } tag_ent_t;

   typedef struct packed {
      logic [Q-1:0]    quotient;
      logic [M-1:0]    remainder;
      logic [TAGW-1:0] tag;
      logic            dz;
      logic            ovf;
   } res_ent_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1 || M >= N) begin : g_bad_params
      $error("divider_issue_ctrl: unsupported parameter set");
   end

   logic [CW-1:0] cnt;
   logic          accept, pop, dz, ovf, tag_empty, res_empty, res_take;
   tag_ent_t      tag_in, tag_head;
   res_ent_t      res_in, res_head;

   assign in_ready = cnt < FULL_CNT;
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // Quotient overflows Q bits exactly when the dividend's top N-Q bits reach the divisor.
   assign dz  = (in_divisor == '0);
   assign ovf = !dz && ({1'b0, in_dividend[N-1:Q]} >= in_divisor);

   assign res_take = res_rdy && !tag_empty;

   always_comb begin
      tag_in.tag = in_tag;
      tag_in.dz  = dz;
      tag_in.ovf = ovf;

      res_in.tag       = tag_head.tag;
      res_in.dz        = tag_head.dz;
      res_in.ovf       = tag_head.ovf;
      res_in.quotient  = res_quotient;
      res_in.remainder = res_remainder;
      if (tag_head.dz || tag_head.ovf) begin
         res_in.quotient  = '1;
         res_in.remainder = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt          <= '0;
         div_en       <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         err          <= 1'b0;
      end else begin
         case ({accept, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         div_en <= accept;
         if (accept) begin
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
         end
         if (res_rdy && tag_empty)
            err <= 1'b1;
      end
   end

   divider_issue_ctrl_fifo #(.W($bits(tag_ent_t)), .DEPTH(DEPTH)) u_tag_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (accept),
      .push_dat (tag_in),
      .pop      (res_take),
      .pop_dat  (tag_head),
      .empty    (tag_empty)
   );

   divider_issue_ctrl_fifo #(.W($bits(res_ent_t)), .DEPTH(DEPTH)) u_res_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (res_take),
      .push_dat (res_in),
      .pop      (pop),
      .pop_dat  (res_head),
      .empty    (res_empty)
   );

   assign out_valid     = !res_empty;
   assign out_quotient  = res_head.quotient;
   assign out_remainder = res_head.remainder;
   assign out_tag       = res_head.tag;
   assign out_dz        = res_head.dz;
   assign out_ovf       = res_head.ovf;
endmodule

// First-word fall-through FIFO; storage resets to zero so the head reads 0 after reset.
// Caller guarantees no push when full and no pop when empty.
module divider_issue_ctrl_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

// File: tb/tb_divider_issue_ctrl.sv
// Directed bench: default-size controller plus a DEPTH=16 copy used for sustained streaming.
module tb_divider_issue_ctrl;
   localparam int N = 16, M = 8, Q = 9, LAT = 9, TAGW = 4;
   typedef logic [Q+M+TAGW+1:0] rec_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // default instance
   logic in_valid = 0, in_ready, div_en, res_rdy, out_valid, out_ready = 0, out_dz, out_ovf, err, stray = 0;
   logic [N-1:0] in_dividend = '0, div_dividend;
   logic [M-1:0] in_divisor = '0, div_divisor, res_remainder, out_remainder;
   logic [TAGW-1:0] in_tag = '0, out_tag;
   logic [Q-1:0] res_quotient, out_quotient;

   divider_issue_ctrl dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
      .div_en(div_en), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .res_rdy(res_rdy), .res_quotient(res_quotient), .res_remainder(res_remainder),
      .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
      .out_remainder(out_remainder), .out_tag(out_tag), .out_dz(out_dz),
      .out_ovf(out_ovf), .err(err)
   );

   // streaming instance
   logic s_in_valid = 0, s_in_ready, s_div_en, s_res_rdy, s_out_valid, s_out_ready = 0, s_out_dz, s_out_ovf, s_err;
   logic [N-1:0] s_in_dividend = '0, s_div_dividend;
   logic [M-1:0] s_in_divisor = '0, s_div_divisor, s_res_remainder, s_out_remainder;
   logic [TAGW-1:0] s_in_tag = '0, s_out_tag;
   logic [Q-1:0] s_res_quotient, s_out_quotient;

   divider_issue_ctrl #(.DEPTH(16)) dut_s (
      .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_dividend(s_in_dividend), .in_divisor(s_in_divisor), .in_tag(s_in_tag),
      .div_en(s_div_en), .div_dividend(s_div_dividend), .div_divisor(s_div_divisor),
      .res_rdy(s_res_rdy), .res_quotient(s_res_quotient), .res_remainder(s_res_remainder),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_quotient(s_out_quotient),
      .out_remainder(s_out_remainder), .out_tag(s_out_tag), .out_dz(s_out_dz),
      .out_ovf(s_out_ovf), .err(s_err)
   );

   // Divider chain models: fixed LAT-cycle delay, garbage results on divide-by-zero.
   logic [LAT-1:0] c0_v, c1_v;
   logic [Q-1:0] c0_q [LAT], c1_q [LAT];
   logic [M-1:0] c0_r [LAT], c1_r [LAT];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c0_v <= '0;
         c1_v <= '0;
      end else begin
         c0_v <= {c0_v[LAT-2:0], div_en};
         c1_v <= {c1_v[LAT-2:0], s_div_en};
         c0_q[0] <= (div_divisor == 0) ? 9'h0AA : 9'(div_dividend / {8'd0, div_divisor});
         c0_r[0] <= (div_divisor == 0) ? 8'h55 : 8'(div_dividend % {8'd0, div_divisor});
         c1_q[0] <= (s_div_divisor == 0) ? 9'h0AA : 9'(s_div_dividend / {8'd0, s_div_divisor});
         c1_r[0] <= (s_div_divisor == 0) ? 8'h55 : 8'(s_div_dividend % {8'd0, s_div_divisor});
         for (int i = 1; i < LAT; i++) begin
            c0_q[i] <= c0_q[i-1];
            c0_r[i] <= c0_r[i-1];
            c1_q[i] <= c1_q[i-1];
            c1_r[i] <= c1_r[i-1];
         end
      end
   end

   assign res_rdy         = c0_v[LAT-1] | stray;
   assign res_quotient    = c0_q[LAT-1];
   assign res_remainder   = c0_r[LAT-1];
   assign s_res_rdy       = c1_v[LAT-1];
   assign s_res_quotient  = c1_q[LAT-1];
   assign s_res_remainder = c1_r[LAT-1];

   // Popped-result logs with the cycle of each pop.
   rec_t q0[$], q1[$];
   int   q0c[$], q1c[$];
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q0.push_back({out_quotient, out_remainder, out_tag, out_dz, out_ovf});
         q0c.push_back(cyc);
      end
      if (s_out_valid && s_out_ready) begin
         q1.push_back({s_out_quotient, s_out_remainder, s_out_tag, s_out_dz, s_out_ovf});
         q1c.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAGW-1:0] t);
      in_valid = 1'b1;
      in_dividend = a;
      in_divisor = b;
      in_tag = t;
      tick();
   endtask

   task automatic wait_q0(input int want);
      int n = 0;
      while (q0.size() < want && n < 80) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #23;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tests++; if (div_en !== 1'b0) begin fails++; $display("FAIL reset_div_en: got %b want 0", div_en); end
      tests++; if (div_dividend !== 16'd0) begin fails++; $display("FAIL reset_div_dividend: got %h want 0", div_dividend); end
      tests++; if (div_divisor !== 8'd0) begin fails++; $display("FAIL reset_div_divisor: got %h want 0", div_divisor); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests++; if ({out_quotient, out_remainder, out_tag, out_dz, out_ovf} !== 23'd0) begin
         fails++; $display("FAIL reset_out_fields: got %h want 0", {out_quotient, out_remainder, out_tag, out_dz, out_ovf}); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      @(posedge clk);
      #1 rstn = 1'b1;
      tick();
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_single();
      int lat;
      out_ready = 1'b0;
      send(16'd1000, 8'd7, 4'd3);
      in_valid = 1'b0;
      tests++; if ({div_en, div_dividend, div_divisor} !== {1'b1, 16'd1000, 8'd7}) begin
         fails++; $display("FAIL single_issue: got en %b %0d/%0d want 1 1000/7", div_en, div_dividend, div_divisor); end
      tick();
      tests++; if ({div_en, div_dividend, div_divisor} !== {1'b0, 16'd1000, 8'd7}) begin
         fails++; $display("FAIL single_issue_hold: got en %b %0d/%0d want 0 1000/7", div_en, div_dividend, div_divisor); end
      lat = 2;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      tests++; if (lat != 11) begin fails++; $display("FAIL single_latency: got %0d want 11", lat); end
      tests++; if ({out_quotient, out_remainder, out_tag, out_dz, out_ovf} !== {9'd142, 8'd6, 4'd3, 2'b00}) begin
         fails++; $display("FAIL single_result: got q %0d r %0d tag %0d dz %b ovf %b want 142 6 3 0 0",
                           out_quotient, out_remainder, out_tag, out_dz, out_ovf); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL single_pop: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_dz();
      rec_t exp [3] = '{{9'd10, 8'd0, 4'd1, 2'b00}, {9'h1FF, 8'd0, 4'd5, 2'b10}, {9'd19, 8'd1, 4'd2, 2'b00}};
      q0.delete();
      out_ready = 1'b1;
      send(16'd100, 8'd10, 4'd1);
      send(16'd200, 8'd0, 4'd5);
      send(16'd77, 8'd4, 4'd2);
      in_valid = 1'b0;
      wait_q0(3);
      for (int i = 0; i < 3; i++) begin
         rec_t got = (i < q0.size()) ? q0[i] : 'x;
         tests++; if (got !== exp[i]) begin fails++; $display("FAIL dz_result%0d: got %h want %h", i, got, exp[i]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_ovf();
      rec_t exp [3] = '{{9'h1FF, 8'd0, 4'd6, 2'b01}, {9'd511, 8'd2, 4'd7, 2'b00}, {9'h1FF, 8'd0, 4'd8, 2'b01}};
      q0.delete();
      out_ready = 1'b1;
      send(16'd60000, 8'd3, 4'd6);
      send(16'd1535, 8'd3, 4'd7);
      send(16'd1536, 8'd3, 4'd8);
      in_valid = 1'b0;
      wait_q0(3);
      for (int i = 0; i < 3; i++) begin
         rec_t got = (i < q0.size()) ? q0[i] : 'x;
         tests++; if (got !== exp[i]) begin fails++; $display("FAIL ovf_result%0d: got %h want %h", i, got, exp[i]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      rec_t exp [4] = '{{9'd3, 8'd1, 4'd0, 2'b00}, {9'd3, 8'd2, 4'd1, 2'b00},
                        {9'd4, 8'd0, 4'd2, 2'b00}, {9'd4, 8'd1, 4'd3, 2'b00}};
      int n = 0;
      q0.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'(10 + i), 8'd3, 4'(i));
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full: in_ready %b want 0", in_ready); end
      in_dividend = 16'd999;
      in_tag = 4'd9;
      repeat (3) tick();
      tests++; if (div_en !== 1'b0 || in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_ignore: div_en %b in_ready %b want 0 0", div_en, in_ready); end
      in_valid = 1'b0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      tests++; if ({out_valid, out_tag, in_ready} !== {1'b1, 4'd0, 1'b0}) begin
         fails++; $display("FAIL bp_head: out_valid %b tag %0d in_ready %b want 1 0 0", out_valid, out_tag, in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (in_ready !== 1'b1 || q0.size() != 1) begin
         fails++; $display("FAIL bp_one_pop: in_ready %b pops %0d want 1 1", in_ready, q0.size()); end
      out_ready = 1'b1;
      wait_q0(4);
      repeat (15) tick();
      out_ready = 1'b0;
      tests++; if (q0.size() != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", q0.size()); end
      for (int i = 0; i < 4; i++) begin
         rec_t got = (i < q0.size()) ? q0[i] : 'x;
         tests++; if (got !== exp[i]) begin fails++; $display("FAIL bp_order%0d: got %h want %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_stream();
      bit ready_ok = 1'b1;
      int n = 0;
      q1.delete();
      q1c.delete();
      s_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_in_valid = 1'b1;
         s_in_dividend = 16'(7 * i + i % 7);
         s_in_divisor = 8'd7;
         s_in_tag = 4'(i);
         if (s_in_ready !== 1'b1) ready_ok = 1'b0;
         tick();
      end
      s_in_valid = 1'b0;
      tests++; if (!ready_ok) begin fails++; $display("FAIL stream_in_ready: dropped low, want always 1"); end
      while (q1.size() < 20 && n < 80) begin
         tick();
         n++;
      end
      tests++; if (q1.size() != 20) begin fails++; $display("FAIL stream_count: got %0d want 20", q1.size()); end
      for (int i = 0; i < 20; i++) begin
         rec_t want = {9'(i), 8'(i % 7), 4'(i), 2'b00};
         rec_t got = (i < q1.size()) ? q1[i] : 'x;
         tests++; if (got !== want) begin fails++; $display("FAIL stream_result%0d: got %h want %h", i, got, want); end
      end
      if (q1.size() == 20) begin
         tests++; if (q1c[19] - q1c[0] != 19) begin
            fails++; $display("FAIL stream_consecutive: span %0d want 19", q1c[19] - q1c[0]); end
      end
      s_out_ready = 1'b0;
   endtask

   task automatic test_stray();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin
         fails++; $display("FAIL stray_set: err %b out_valid %b want 1 0", err, out_valid); end
      repeat (5) tick();
      tests++; if ({err, out_valid, in_ready} !== 3'b101) begin
         fails++; $display("FAIL stray_sticky: err %b out_valid %b in_ready %b want 1 0 1", err, out_valid, in_ready); end
      q0.delete();
      out_ready = 1'b1;
      send(16'd1000, 8'd7, 4'd3);
      in_valid = 1'b0;
      wait_q0(1);
      out_ready = 1'b0;
      begin
         rec_t got = (q0.size() > 0) ? q0[0] : 'x;
         tests++; if (got !== {9'd142, 8'd6, 4'd3, 2'b00} || err !== 1'b1) begin
            fails++; $display("FAIL stray_after: got %h err %b want %h 1", got, err, {9'd142, 8'd6, 4'd3, 2'b00}); end
      end
   endtask

   task automatic test_reset_midflight();
      bit seen = 1'b0;
      q0.delete();
      out_ready = 1'b0;
      send(16'd500, 8'd5, 4'd1);
      send(16'd501, 8'd5, 4'd2);
      send(16'd502, 8'd5, 4'd3);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      tests++; if ({in_ready, div_en, div_dividend, div_divisor} !== {1'b1, 1'b0, 16'd0, 8'd0}) begin
         fails++; $display("FAIL midreset_issue: in_ready %b div_en %b %0d/%0d want 1 0 0/0",
                           in_ready, div_en, div_dividend, div_divisor); end
      tests++; if ({out_valid, err, out_quotient, out_remainder, out_tag, out_dz, out_ovf} !== 25'd0) begin
         fails++; $display("FAIL midreset_out: out_valid %b err %b fields %h want 0 0 0", out_valid, err,
                           {out_quotient, out_remainder, out_tag, out_dz, out_ovf}); end
      @(posedge clk);
      #1 rstn = 1'b1;
      out_ready = 1'b1;
      repeat (20) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      tests++; if (seen || q0.size() != 0) begin
         fails++; $display("FAIL midreset_no_results: seen %b pops %0d want 0 0", seen, q0.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_dz();
      test_ovf();
      test_backpressure();
      test_stream();
      test_stray();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
